// File: rtl/noc_pkg.sv
// Shared NoC definitions: address fields,
// port indices and routing helpers.
package noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int NUM_LEAVES = 4;
  localparam int PORT_LEAF0 = 0;
  localparam int PORT_LEAF1 = 1;
  localparam int PORT_LEAF2 = 2;
  localparam int PORT_LEAF3 = 3;
  localparam int PORT_UP    = 4;

  localparam int ADDR_W    = 6;
  localparam int GROUP_MSB = 5;
  localparam int GROUP_LSB = 2;
  localparam int LEAF_MSB  = 1;
  localparam int LEAF_LSB  = 0;

  localparam int DROP_CNT_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [2:0]        port_t;

  // Output port a destination address resolves to.
  function automatic port_t route(addr_t dest, logic [3:0] gid);
    if (dest[GROUP_MSB:GROUP_LSB] == gid)
      return port_t'(dest[LEAF_MSB:LEAF_LSB]);
    return port_t'(PORT_UP);
  endfunction

  // Next port index, wrapping after the uplink.
  function automatic port_t port_inc(port_t p);
    if (p == port_t'(NUM_PORTS - 1))
      return '0;
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/spine_switch_if.sv
// Spine switch bus: leaf/uplink ingress and
// egress plus status.
interface spine_switch_if
  import noc_pkg::*;
#(
  parameter int DWIDTH = 16
);

  logic                         arb_enable;
  logic [NUM_LEAVES*DWIDTH-1:0] leaf_in_data;
  logic [NUM_LEAVES-1:0]        leaf_in_valid;
  logic [NUM_LEAVES*ADDR_W-1:0] leaf_in_dest_addr;
  logic [NUM_LEAVES*DWIDTH-1:0] leaf_out_data;
  logic [NUM_LEAVES-1:0]        leaf_out_valid;
  logic [NUM_LEAVES*ADDR_W-1:0] leaf_out_dest_addr;
  logic [DWIDTH-1:0]            up_in_data;
  logic                         up_in_valid;
  addr_t                        up_in_dest_addr;
  logic [DWIDTH-1:0]            up_out_data;
  logic                         up_out_valid;
  addr_t                        up_out_dest_addr;
  logic [NUM_PORTS-1:0]         fifo_full;
  logic [NUM_PORTS-1:0]         fifo_empty;
  logic [DROP_CNT_W-1:0]        drop_count;
  logic                         busy;

  modport master (
    output arb_enable,
    output leaf_in_data, leaf_in_valid,
    output leaf_in_dest_addr,
    output up_in_data, up_in_valid,
    output up_in_dest_addr,
    input  leaf_out_data, leaf_out_valid,
    input  leaf_out_dest_addr,
    input  up_out_data, up_out_valid,
    input  up_out_dest_addr,
    input  fifo_full, fifo_empty,
    input  drop_count, busy
  );

  modport slave (
    input  arb_enable,
    input  leaf_in_data, leaf_in_valid,
    input  leaf_in_dest_addr,
    input  up_in_data, up_in_valid,
    input  up_in_dest_addr,
    output leaf_out_data, leaf_out_valid,
    output leaf_out_dest_addr,
    output up_out_data, up_out_valid,
    output up_out_dest_addr,
    output fifo_full, fifo_empty,
    output drop_count, busy
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// Input FIFO; head_ready flags a head that
// has been buffered for at least one cycle.
module noc_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             head_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    aged;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_data  = mem[rd_ptr];
  assign head_ready = (aged != '0);

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and aged-entry count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      aged   <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      aged  <= count - CW'(do_pop);
    end
  end

endmodule

// File: rtl/spine_switch.sv
// Spine switch: 5 buffered inputs, per-output
// round-robin arbitration, registered outputs.
module spine_switch
  import noc_pkg::*;
#(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] GROUP_ID   = 4'b0001
) (
  input  logic           clk,
  input  logic           reset,
  spine_switch_if.slave  bus
);

  localparam int EW = ADDR_W + DWIDTH;
  localparam int SW = DROP_CNT_W + 1;

  logic [NUM_PORTS-1:0]           in_valid;
  logic [NUM_PORTS-1:0][EW-1:0]   in_ent;
  logic [NUM_PORTS-1:0]           misroute;
  logic [NUM_PORTS-1:0]           push;
  logic [NUM_PORTS-1:0]           drop;
  logic [NUM_PORTS-1:0]           pop;
  logic [NUM_PORTS-1:0]           full;
  logic [NUM_PORTS-1:0]           empty;
  logic [NUM_PORTS-1:0]           ready;
  logic [NUM_PORTS-1:0][EW-1:0]   head;
  port_t [NUM_PORTS-1:0]          tgt;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0]           any_gnt;
  port_t [NUM_PORTS-1:0]          gsel;
  port_t                          idx;
  port_t [NUM_PORTS-1:0]          ptr;
  logic [NUM_PORTS-1:0]           out_valid;
  logic [NUM_PORTS-1:0][EW-1:0]   out_ent;
  logic [DROP_CNT_W-1:0]          drop_count;
  logic [2:0]                     drop_n;
  logic [SW-1:0]                  drop_sum;

  // Gather inputs; filter misroutes and full FIFOs.
  always_comb begin
    for (int p = 0; p < NUM_LEAVES; p++) begin
      in_valid[p] = bus.leaf_in_valid[p];
      in_ent[p]   = {bus.leaf_in_dest_addr[p*ADDR_W +: ADDR_W],
                     bus.leaf_in_data[p*DWIDTH +: DWIDTH]};
    end
    in_valid[PORT_UP] = bus.up_in_valid;
    in_ent[PORT_UP]   = {bus.up_in_dest_addr, bus.up_in_data};
    misroute          = '0;
    misroute[PORT_UP] = bus.up_in_valid &&
      (bus.up_in_dest_addr[GROUP_MSB:GROUP_LSB] != GROUP_ID);
    push = in_valid & ~misroute & ~full;
    drop = in_valid & (misroute | full);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
    noc_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push[p]),
      .pop        (pop[p]),
      .push_data  (in_ent[p]),
      .head_data  (head[p]),
      .full       (full[p]),
      .empty      (empty[p]),
      .head_ready (ready[p])
    );
  end

  // Round-robin pick per output from its pointer.
  always_comb begin
    req     = '0;
    gnt     = '0;
    any_gnt = '0;
    gsel    = '0;
    pop     = '0;
    idx     = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      tgt[p] = route(head[p][EW-1 -: ADDR_W], GROUP_ID);
    for (int o = 0; o < NUM_PORTS; o++)
      for (int p = 0; p < NUM_PORTS; p++)
        req[o][p] = bus.arb_enable && ready[p] &&
                    (tgt[p] == port_t'(o));
    for (int o = 0; o < NUM_PORTS; o++) begin
      idx = ptr[o];
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!any_gnt[o] && req[o][idx]) begin
          gnt[o][idx] = 1'b1;
          any_gnt[o]  = 1'b1;
          gsel[o]     = idx;
        end
        idx = port_inc(idx);
      end
      pop = pop | gnt[o];
    end
  end

  // Sum this cycle's drops for the counter.
  always_comb begin
    drop_n = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      drop_n = drop_n + 3'(drop[p]);
    drop_sum = {1'b0, drop_count} + SW'(drop_n);
  end

  // Output registers, pointers, drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      out_valid  <= '0;
      out_ent    <= '0;
      drop_count <= '0;
    end else begin
      out_valid <= any_gnt;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (any_gnt[o]) begin
          out_ent[o] <= head[gsel[o]];
          ptr[o]     <= port_inc(gsel[o]);
        end
      end
      if (drop_sum[SW-1])
        drop_count <= '1;
      else
        drop_count <= drop_sum[DROP_CNT_W-1:0];
    end
  end

  // Fan registered outputs and status to the bus.
  always_comb begin
    for (int i = 0; i < NUM_LEAVES; i++) begin
      bus.leaf_out_valid[i] = out_valid[i];
      bus.leaf_out_data[i*DWIDTH +: DWIDTH] =
        out_ent[i][DWIDTH-1:0];
      bus.leaf_out_dest_addr[i*ADDR_W +: ADDR_W] =
        out_ent[i][EW-1 -: ADDR_W];
    end
    bus.up_out_valid     = out_valid[PORT_UP];
    bus.up_out_data      = out_ent[PORT_UP][DWIDTH-1:0];
    bus.up_out_dest_addr = out_ent[PORT_UP][EW-1 -: ADDR_W];
    bus.fifo_full        = full;
    bus.fifo_empty       = empty;
    bus.drop_count       = drop_count;
    bus.busy             = (|(~empty)) || (|out_valid);
  end

endmodule

// File: tb/tb_spine_switch.sv
// Spine switch bench: directed scenarios plus
// random traffic against a queue-level model.
module tb_spine_switch;

  localparam int         DW    = 16;
  localparam int         DEPTH = 4;
  localparam logic [3:0] GID   = 4'b0001;

  typedef struct {
    logic [5:0]  dest;
    logic [15:0] data;
    int          t;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  spine_switch_if #(.DWIDTH(DW)) bus ();

  spine_switch #(
    .DWIDTH     (DW),
    .FIFO_DEPTH (DEPTH),
    .GROUP_ID   (GID)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq [5][$];
  int          mptr [5];
  logic [4:0]  m_valid = '0;
  logic [15:0] m_data [5];
  logic [5:0]  m_dest [5];
  int          m_drops = 0;
  int          edge_n  = 0;

  bit          col_en   = 0;
  int          col_port = 0;
  logic [15:0] col_q [$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int tgt(logic [5:0] d);
    if (d[5:2] == GID)
      return int'(d[1:0]);
    return 4;
  endfunction

  task automatic model_step();
    int          sz0 [5];
    bit          pp [5];
    int          nd;
    int          p;
    logic        v;
    logic [5:0]  d;
    logic [15:0] x;
    edge_n++;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        mq[i].delete();
        mptr[i]   = 0;
        m_data[i] = '0;
        m_dest[i] = '0;
      end
      m_valid = '0;
      m_drops = 0;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      sz0[i] = mq[i].size();
      pp[i]  = 0;
    end
    for (int o = 0; o < 5; o++) begin
      m_valid[o] = 1'b0;
      if (bus.arb_enable) begin
        for (int k = 0; k < 5; k++) begin
          p = (mptr[o] + k) % 5;
          if (!m_valid[o] && !pp[p] && sz0[p] > 0 &&
              mq[p][0].t <= edge_n - 2 &&
              tgt(mq[p][0].dest) == o) begin
            m_valid[o] = 1'b1;
            m_data[o]  = mq[p][0].data;
            m_dest[o]  = mq[p][0].dest;
            mptr[o]    = (p + 1) % 5;
            pp[p]      = 1;
          end
        end
      end
    end
    for (int i = 0; i < 5; i++)
      if (pp[i]) void'(mq[i].pop_front());
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        v = bus.leaf_in_valid[i];
        d = bus.leaf_in_dest_addr[i*6 +: 6];
        x = bus.leaf_in_data[i*DW +: DW];
      end else begin
        v = bus.up_in_valid;
        d = bus.up_in_dest_addr;
        x = bus.up_in_data;
      end
      if (v) begin
        if (i == 4 && d[5:2] != GID)
          nd++;
        else if (sz0[i] == DEPTH)
          nd++;
        else
          mq[i].push_back('{d, x, edge_n});
      end
    end
    m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
  endtask

  task automatic compare_all();
    logic [4:0] fe;
    logic [4:0] ff;
    logic       bz;
    for (int o = 0; o < 4; o++) begin
      check($sformatf("leaf%0d_valid", o),
            64'(bus.leaf_out_valid[o]), 64'(m_valid[o]));
      check($sformatf("leaf%0d_data", o),
            64'(bus.leaf_out_data[o*DW +: DW]),
            64'(m_data[o]));
      check($sformatf("leaf%0d_dest", o),
            64'(bus.leaf_out_dest_addr[o*6 +: 6]),
            64'(m_dest[o]));
    end
    check("up_valid", 64'(bus.up_out_valid), 64'(m_valid[4]));
    check("up_data", 64'(bus.up_out_data), 64'(m_data[4]));
    check("up_dest", 64'(bus.up_out_dest_addr), 64'(m_dest[4]));
    bz = |m_valid;
    for (int i = 0; i < 5; i++) begin
      fe[i] = (mq[i].size() == 0);
      ff[i] = (mq[i].size() == DEPTH);
      if (mq[i].size() != 0) bz = 1'b1;
    end
    check("fifo_empty", 64'(bus.fifo_empty), 64'(fe));
    check("fifo_full", 64'(bus.fifo_full), 64'(ff));
    check("drop_count", 64'(bus.drop_count), 64'(m_drops));
    check("busy", 64'(bus.busy), 64'(bz));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (col_en) begin
      if (col_port < 4) begin
        if (bus.leaf_out_valid[col_port])
          col_q.push_back(bus.leaf_out_data[col_port*DW +: DW]);
      end else if (bus.up_out_valid) begin
        col_q.push_back(bus.up_out_data);
      end
    end
  endtask

  task automatic idle();
    bus.leaf_in_valid = '0;
    bus.up_in_valid   = 1'b0;
  endtask

  task automatic send_leaf(input int p,
                           input logic [5:0] d,
                           input logic [15:0] x);
    bus.leaf_in_valid[p]          = 1'b1;
    bus.leaf_in_dest_addr[p*6 +: 6] = d;
    bus.leaf_in_data[p*DW +: DW]  = x;
  endtask

  task automatic send_up(input logic [5:0] d,
                         input logic [15:0] x);
    bus.up_in_valid     = 1'b1;
    bus.up_in_dest_addr = d;
    bus.up_in_data      = x;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int exp41 [6] = '{0, 1, 3, 0, 1, 3};
  logic [15:0] w;

  initial begin
    bus.arb_enable        = 1'b1;
    bus.leaf_in_valid     = '0;
    bus.leaf_in_data      = '0;
    bus.leaf_in_dest_addr = '0;
    bus.up_in_valid       = 1'b0;
    bus.up_in_data        = '0;
    bus.up_in_dest_addr   = '0;

    do_reset();
    check("rst_empty", 64'(bus.fifo_empty), 64'h1f);
    check("rst_full", 64'(bus.fifo_full), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_drops", 64'(bus.drop_count), 64'h0);

    send_leaf(0, 6'b000110, 16'hA5A5);
    step();
    idle();
    step();
    check("l0_early", 64'(bus.leaf_out_valid), 64'h0);
    step();
    check("l0_valid", 64'(bus.leaf_out_valid), 64'h4);
    check("l0_data", 64'(bus.leaf_out_data[47:32]), 64'hA5A5);
    check("l0_dest", 64'(bus.leaf_out_dest_addr[17:12]),
          64'b000110);
    check("l0_up", 64'(bus.up_out_valid), 64'h0);
    step();

    send_leaf(1, 6'b001100, 16'h1234);
    step();
    idle();
    step();
    step();
    check("up_pulse", 64'(bus.up_out_valid), 64'h1);
    check("up_pdest", 64'(bus.up_out_dest_addr), 64'b001100);
    send_up(6'b001001, 16'h5555);
    step();
    idle();
    check("misroute", 64'(bus.drop_count), 64'h1);
    step();

    do_reset();
    col_en   = 1;
    col_port = 2;
    col_q.delete();
    for (int c = 0; c < 6; c++) begin
      send_leaf(0, 6'b000110, {4'd0, 12'(c)});
      send_leaf(1, 6'b000110, {4'd1, 12'(c)});
      send_leaf(3, 6'b000110, {4'd3, 12'(c)});
      step();
    end
    idle();
    for (int c = 0; c < 20; c++) step();
    col_en = 0;
    check("rr_count", 64'(col_q.size() >= 6), 64'h1);
    for (int i = 0; i < 6 && i < col_q.size(); i++) begin
      w = col_q[i];
      check($sformatf("rr_order%0d", i),
            64'(w[15:12]), 64'(exp41[i]));
    end

    do_reset();
    bus.arb_enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      send_leaf(0, 6'b000101, 16'h4200 + 16'(c));
      step();
      if (c == 3)
        check("full_after4", 64'(bus.fifo_full[0]), 64'h1);
    end
    idle();
    check("fifth_drop", 64'(bus.drop_count), 64'h1);
    step();
    check("held_valid", 64'(bus.leaf_out_valid), 64'h0);
    bus.arb_enable = 1'b1;
    col_en   = 1;
    col_port = 1;
    col_q.delete();
    for (int c = 0; c < 10; c++) step();
    col_en = 0;
    check("drain_count", 64'(col_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < col_q.size(); i++)
      check($sformatf("drain%0d", i),
            64'(col_q[i]), 64'(16'h4200 + 16'(i)));

    do_reset();
    bus.arb_enable = 1'b0;
    for (int c = 0; c < 70; c++) begin
      for (int p = 0; p < 4; p++)
        send_leaf(p, 6'b000100, 16'(c));
      send_up(6'b111100, 16'(c));
      step();
    end
    idle();
    check("drop_sat", 64'(bus.drop_count), 64'd255);
    step();

    do_reset();
    bus.arb_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      send_leaf(0, 6'b000111, 16'(c));
      step();
    end
    idle();
    bus.arb_enable = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_empty", 64'(bus.fifo_empty), 64'h1f);
    check("mid_rst_valid",
          64'({bus.up_out_valid, bus.leaf_out_valid}), 64'h0);
    check("mid_rst_drops", 64'(bus.drop_count), 64'h0);
    for (int c = 0; c < 4; c++) step();

    for (int c = 0; c < 3000; c++) begin
      logic [5:0] d;
      bus.arb_enable = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 499) == 0);
      for (int p = 0; p < 5; p++) begin
        d = 6'($urandom);
        if ($urandom_range(0, 3) != 0) d[5:2] = GID;
        if ($urandom_range(0, 1) == 1) begin
          if (p < 4) send_leaf(p, d, 16'($urandom));
          else       send_up(d, 16'($urandom));
        end else begin
          if (p < 4) bus.leaf_in_valid[p] = 1'b0;
          else       bus.up_in_valid = 1'b0;
        end
      end
      step();
    end
    reset = 1'b0;
    idle();
    bus.arb_enable = 1'b1;
    for (int c = 0; c < 30; c++) step();
    check("final_empty", 64'(bus.fifo_empty), 64'h1f);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
